cent_input_cond: RTL and testbench



---
 rtl/cent_input_pkg.sv | 15 +
 rtl/cent_debounce.sv | 106 ++++++++++
 rtl/cent_input_cond.sv | 35 +++
 tb/tb_cent_input_cond.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cent_input_pkg.sv
// Shared constants for the cabinet input conditioner: channel map and 50 MHz timing defaults.
package cent_input_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CH_SWITCH = 0;
    localparam int unsigned CH_BTN1   = 1;
    localparam int unsigned CH_BTN2   = 2;
    localparam int unsigned CH_BTN3   = 3;

    localparam int unsigned SYSCLK_HZ           = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;  // 20 ms
    localparam int unsigned AUTOFIRE_PERIOD_DEF = 2_500_000;  // 50 ms
    localparam logic [NUM_CH-1:0] AUTOFIRE_MASK_DEF = 4'b0010;

endpackage

// File: rtl/cent_debounce.sv
// One input channel: 2-flop synchronizer, debounce counter, level and press/release pulses.
// Auto-repeat of press is built only when CENT_INPUT_AUTOFIRE_EN is defined.
module cent_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int unsigned AUTOFIRE_PERIOD = 2_500_000,
    parameter bit          AUTOFIRE_EN     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept;
    logic             repeat_fire;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            accept  = 1'b1;
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign press_d   = (accept & s2_q) | repeat_fire;
    assign release_d = accept & ~s2_q;

`ifdef CENT_INPUT_AUTOFIRE_EN
    if (AUTOFIRE_EN) begin : g_af
        localparam int unsigned AfW = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;
        localparam logic [AfW-1:0] RepMax = AfW'(AUTOFIRE_PERIOD - 1);

        logic [AfW-1:0] rep_q, rep_d;
        logic           fire;

        // Repeat phase restarts at every accepted edge and idles while released.
        always_comb begin
            rep_d = rep_q;
            fire  = 1'b0;
            if (accept || !level_q) begin
                rep_d = '0;
            end else if (rep_q == RepMax) begin
                rep_d = '0;
                fire  = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) rep_q <= '0;
            else         rep_q <= rep_d;
        end

        assign repeat_fire = fire;
    end else begin : g_no_af
        logic unused_af;
        assign unused_af   = ^AUTOFIRE_PERIOD;
        assign repeat_fire = 1'b0;
    end
`else
    logic unused_af;
    assign unused_af   = ^{AUTOFIRE_PERIOD, AUTOFIRE_EN};
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/cent_input_cond.sv
// Cabinet input conditioner: one debounced channel per raw input {button3..1, switch}.
// Define CENT_INPUT_AUTOFIRE_EN to build auto-repeat on channels selected by AUTOFIRE_MASK.
module cent_input_cond
    import cent_input_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned       CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int unsigned       AUTOFIRE_PERIOD = AUTOFIRE_PERIOD_DEF,
    parameter logic [NUM_CH-1:0] AUTOFIRE_MASK   = AUTOFIRE_MASK_DEF
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] in_level,
    output logic [NUM_CH-1:0] in_press,
    output logic [NUM_CH-1:0] in_release
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cent_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .AUTOFIRE_PERIOD (AUTOFIRE_PERIOD),
            .AUTOFIRE_EN     (AUTOFIRE_MASK[i])
        ) u_debounce (
            .clk_i     (sysclk),
            .rst_ni    (reset_n),
            .raw_i     (raw_in[i]),
            .level_o   (in_level[i]),
            .press_o   (in_press[i]),
            .release_o (in_release[i])
        );
    end

endmodule

// File: tb/tb_cent_input_cond.sv
// Scoreboard bench for cent_input_cond: history-window reference model plus directed checks.
module tb_cent_input_cond;

    localparam int unsigned D = 8;
    localparam int unsigned P = 16;
    localparam logic [3:0]  MASK = 4'b0010;
`ifdef CENT_INPUT_AUTOFIRE_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic [3:0] raw_in;
    logic [3:0] in_level, in_press, in_release;

    always #5 sysclk = ~sysclk;

    cent_input_cond #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           ($clog2(D)),
        .AUTOFIRE_PERIOD (P),
        .AUTOFIRE_MASK   (MASK)
    ) dut (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .in_level   (in_level),
        .in_press   (in_press),
        .in_release (in_release)
    );

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rls;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    exp_t       exp_q[$];
    logic [3:0] hist[$];
    logic [3:0] m_lvl;
    logic [3:0] af_mask = MASK;
    int         af_age[4];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a level flips once the synchronized input (raw delayed two edges) has
    // disagreed with it for D consecutive edges; repeats every P edges after acceptance.
    always @(posedge sysclk) begin
        exp_t e;
        bit   stable;
        int   idx;
        e = '0;
        if (!reset_n) begin
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_back(4'b0000);
            m_lvl = '0;
            for (int c = 0; c < 4; c++) af_age[c] = 0;
        end else begin
            hist.push_back(raw_in);
            while (hist.size() > D + 2) void'(hist.pop_front());
            for (int c = 0; c < 4; c++) begin
                stable = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    idx = hist.size() - 1 - j;
                    if (hist[idx][c] == m_lvl[c]) stable = 1'b0;
                end
                if (stable) begin
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c]) e.prs[c] = 1'b1;
                    else          e.rls[c] = 1'b1;
                    af_age[c] = 0;
                end else if (AF_ON && af_mask[c] && m_lvl[c]) begin
                    af_age[c]++;
                    if (af_age[c] % P == 0) e.prs[c] = 1'b1;
                end
            end
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
    end

    always @(negedge sysclk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {in_level, in_press, in_release}, e);
        end
    end

    task automatic nxt();
        @(negedge sysclk);
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, n1;
        reset_n = 1'b0;
        raw_in  = 4'b1111;
        edges(5);
        check("reset_outputs", {in_level, in_press, in_release}, 12'h000);
        nxt();
        reset_n = 1'b1;
        raw_in  = 4'b0000;
        edges(12);
        check("reset_exit_quiet", {in_level, in_press, in_release}, 12'h000);

        // Clean press on button1.
        nxt();
        raw_in[1] = 1'b1;
        edges(9);
        check("press_before_edge10", 12'(in_level[1]), 12'h0);
        edges(1);
        check("press_at_edge10", 12'({in_level[1], in_press[1]}), 12'h3);
        edges(1);
        check("press_one_cycle", 12'(in_press[1]), 12'h0);

        // Glitch on button2 shorter than the debounce window.
        nxt();
        raw_in[2] = 1'b1;
        repeat (5) nxt();
        raw_in[2] = 1'b0;
        edges(15);
        check("glitch_rejected", 12'(in_level[2]), 12'h0);

        // Simultaneous release on two channels.
        nxt();
        raw_in = 4'b0011;
        edges(12);
        check("levels_settled", 12'(in_level), 12'h003);
        nxt();
        raw_in = 4'b0000;
        edges(9);
        check("release_before", 12'({in_level, in_release}), 12'h30);
        edges(1);
        check("release_simul", 12'({in_level, in_release}), 12'h03);

        // Reset in the middle of a count on button3.
        nxt();
        raw_in[3] = 1'b1;
        repeat (6) nxt();
        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1;
        edges(9);
        check("midreset_before", 12'(in_level[3]), 12'h0);
        edges(1);
        check("midreset_edge10", 12'({in_level[3], in_press[3]}), 12'h3);

        // Hold switch and button1: repeats only where auto-repeat is built and masked.
        nxt();
        raw_in = 4'b1011;
        n0 = 0;
        n1 = 0;
        repeat (70) begin
            edges(1);
            n0 += int'(in_press[0]);
            n1 += int'(in_press[1]);
        end
        check("btn1_press_count", 12'(n1), AF_ON ? 12'd4 : 12'd1);
        check("switch_press_count", 12'(n0), 12'd1);

        nxt();
        raw_in = 4'b0000;
        edges(12);
        check("all_released", 12'(in_level), 12'h000);

        // Random toggling with occasional reset pulses.
        repeat (1500) begin
            nxt();
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(9) == 0) raw_in[c] = ~raw_in[c];
            end
            reset_n = ($urandom_range(299) != 0);
        end
        nxt();
        reset_n = 1'b1;
        raw_in  = 4'b0000;
        edges(20);
        check("final_idle", 12'(in_level), 12'h000);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
